// File: rtl/metronome_tempo_ctrl_if.sv
// Purpose: bundles the key/preset inputs and the tempo, sweep and display outputs of the metronome tempo controller.
// Latency: wiring only, no registers.
// Backpressure: none; every signal is a free-running level or a single-cycle pulse.
// Ports: slave = controller side (metronome_tempo_ctrl), master = board / testbench side.
//   tapup_n, tapdown_n : raw active-low keys, asynchronous to the clock
//   preset, load_preset: preset index and level-sensitive load
//   bpm, hex100/10/0   : tempo in binary and as registered BCD digits
//   step, led, beat    : sweep position, one-hot bounce LED, beat pulse
//   speaker            : click output
interface metronome_tempo_ctrl_if;
  logic       tapup_n;
  logic       tapdown_n;
  logic [4:0] preset;
  logic       load_preset;
  logic [7:0] bpm;
  logic [3:0] hex100;
  logic [3:0] hex10;
  logic [3:0] hex0;
  logic [3:0] step;
  logic [7:0] led;
  logic       beat;
  logic       speaker;

  modport slave (
    input  tapup_n, tapdown_n, preset, load_preset,
    output bpm, hex100, hex10, hex0, step, led, beat, speaker
  );

  modport master (
    output tapup_n, tapdown_n, preset, load_preset,
    input  bpm, hex100, hex10, hex0, step, led, beat, speaker
  );
endinterface

// File: rtl/metronome_tempo_ctrl.sv
// Purpose: metronome tempo register with debounced tap keys and presets, phase-accumulator beat sequencer, LED bounce, click and BCD display.
// Latency: key press -> bpm after sync(2) + DEBOUNCE + 2 cycles; bpm -> BCD digits 1 cycle; step/led/beat/speaker registered together.
// Backpressure: none; inputs are sampled every cycle and outputs are free-running.
// Ports: clock, reset (async active-high, release synchronised internally); bus = metronome_tempo_ctrl_if.slave.
module metronome_tempo_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int BPM_MIN      = 60,
  parameter int BPM_MAX      = 230,
  parameter int BPM_STEP     = 10,
  parameter int STEPS        = 14,
  parameter int DEBOUNCE     = 500000,
  parameter int CLICK_CYCLES = 250000
) (
  input  logic                   clock,
  input  logic                   reset,
  metronome_tempo_ctrl_if.slave  bus
);

  // One sweep step is due every THRESH/bpm cycles: CLK_HZ*60 cycles per minute spread over bpm*STEPS steps.
  localparam longint THRESH  = longint'(CLK_HZ) * 60 / STEPS;
  // The accumulator always sits below THRESH, so acc + bpm never exceeds THRESH + BPM_MAX.
  localparam int     ACC_W   = $clog2(THRESH + BPM_MAX + 1);
  localparam int     DEB_W   = $clog2(DEBOUNCE + 1);
  localparam int     CLK_W   = $clog2(CLICK_CYCLES + 1);
  localparam int     CALC_W  = 16;
  localparam int     CLICK_STEP = STEPS / 2;

  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Shift-and-add-3 binary to BCD; purely combinational, settles in one cycle.
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

  // Bounce order: up the bar on steps 0..7, back down on steps 8..13 without repeating the ends.
  function automatic logic [7:0] led_of(input logic [3:0] s);
    logic [3:0] pos;
    pos = (s < 4'd8) ? s : (4'(STEPS) - s);
    return 8'(1) << pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so that no flop
  // sees reset removal near its active edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // Key path: index 0 = tap-up, index 1 = tap-down.
  // key_state is the accepted level (1 = released). A new level is accepted
  // only after the synchronised input has differed from it for DEBOUNCE
  // consecutive cycles; a press event fires only on the accepted 1->0 edge,
  // so a held key never repeats.
  // ---------------------------------------------------------------------------
  logic [1:0]       key_raw;
  logic [1:0]       key_meta;
  logic [1:0]       key_sync;
  logic [1:0]       key_state;
  logic [1:0]       key_evt;
  logic [DEB_W-1:0] deb_cnt [2];

  assign key_raw = {bus.tapdown_n, bus.tapup_n};

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      key_state <= 2'b11;
      key_evt   <= 2'b00;
      for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
      for (int k = 0; k < 2; k++) begin
        key_evt[k] <= 1'b0;
        if (key_sync[k] == key_state[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_W'(DEBOUNCE - 1)) begin
          deb_cnt[k]   <= '0;
          key_state[k] <= key_sync[k];
          key_evt[k]   <= ~key_sync[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tempo register. Preset load overrides keys; simultaneous up+down cancel;
  // both directions saturate at the range ends. Arithmetic is done wide so
  // the large presets do not wrap before clamping.
  // ---------------------------------------------------------------------------
  logic [7:0]        bpm_q;
  logic [7:0]        bpm_d;
  logic [11:0]       bcd_q;
  logic [CALC_W-1:0] preset_bpm;
  logic [CALC_W-1:0] up_bpm;

  always_comb begin
    preset_bpm = CALC_W'(BPM_MIN) + CALC_W'(BPM_STEP) * CALC_W'(bus.preset);
    if (preset_bpm > CALC_W'(BPM_MAX)) preset_bpm = CALC_W'(BPM_MAX);

    up_bpm = CALC_W'(bpm_q) + CALC_W'(BPM_STEP);
    if (up_bpm > CALC_W'(BPM_MAX)) up_bpm = CALC_W'(BPM_MAX);

    bpm_d = bpm_q;
    if (bus.load_preset) begin
      bpm_d = 8'(preset_bpm);
    end else if (key_evt[0] && key_evt[1]) begin
      bpm_d = bpm_q;
    end else if (key_evt[0]) begin
      bpm_d = 8'(up_bpm);
    end else if (key_evt[1]) begin
      if (CALC_W'(bpm_q) < CALC_W'(BPM_MIN + BPM_STEP)) bpm_d = 8'(BPM_MIN);
      else                                              bpm_d = bpm_q - 8'(BPM_STEP);
    end
  end

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      bpm_q <= 8'(BPM_MIN);
      bcd_q <= to_bcd(8'(BPM_MIN));
    end else begin
      bpm_q <= bpm_d;
      bcd_q <= to_bcd(bpm_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator and sweep. The remainder is carried across each step,
  // so intervals alternate between floor and ceil of THRESH/bpm with no
  // long-run drift, and a tempo change never resets the phase.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_d;
  logic             advance;
  logic [3:0]       step_q;
  logic [3:0]       step_d;
  logic [7:0]       led_q;
  logic             beat_q;
  logic             click_trig;
  logic             speaker_q;
  logic [CLK_W-1:0] click_cnt;

  always_comb begin
    acc_sum = acc_q + ACC_W'(bpm_q);
    advance = (acc_sum >= THRESH_V);
    acc_d   = advance ? (acc_sum - THRESH_V) : acc_sum;

    step_d = step_q;
    if (advance) step_d = (step_q == 4'(STEPS - 1)) ? 4'd0 : (step_q + 4'd1);

    // Click on the downbeat and on the far end of the bounce.
    click_trig = advance && ((step_d == 4'd0) || (step_d == 4'(CLICK_STEP)));
  end

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      acc_q  <= '0;
      step_q <= 4'd0;
      led_q  <= 8'h01;
      beat_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
      led_q  <= led_of(step_d);
      beat_q <= advance && (step_d == 4'd0);
    end
  end

  // Speaker stays high for CLICK_CYCLES cycles from the trigger; a retrigger
  // reloads the counter, so overlapping clicks merge into one long high.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      speaker_q <= 1'b0;
      click_cnt <= '0;
    end else if (click_trig) begin
      speaker_q <= 1'b1;
      click_cnt <= CLK_W'(CLICK_CYCLES - 1);
    end else if (click_cnt != '0) begin
      click_cnt <= click_cnt - 1'b1;
    end else begin
      speaker_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.bpm     = bpm_q;
  assign bus.hex100  = bcd_q[11:8];
  assign bus.hex10   = bcd_q[7:4];
  assign bus.hex0    = bcd_q[3:0];
  assign bus.step    = step_q;
  assign bus.led     = led_q;
  assign bus.beat    = beat_q;
  assign bus.speaker = speaker_q;

endmodule

// File: tb/tb_metronome_tempo_ctrl.sv
// Purpose: self-checking bench for metronome_tempo_ctrl with small clock/debounce/click constants.
// Latency: n/a (testbench).
// Backpressure: n/a; keys are driven as raw levels and outputs sampled on the falling edge.
module tb_metronome_tempo_ctrl;
  localparam int CLK_HZ = 1400;
  localparam int DEB    = 4;
  localparam int CLICK  = 10;
  localparam int STEPS  = 14;
  localparam int BMIN   = 60;
  localparam int BMAX   = 230;
  localparam int BSTEP  = 10;
  localparam int THRESH = CLK_HZ * 60 / STEPS;   // 6000

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_bpm;

  metronome_tempo_ctrl_if bus ();

  metronome_tempo_ctrl #(
    .CLK_HZ(CLK_HZ), .BPM_MIN(BMIN), .BPM_MAX(BMAX), .BPM_STEP(BSTEP),
    .STEPS(STEPS), .DEBOUNCE(DEB), .CLICK_CYCLES(CLICK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- reference model
  function automatic int ref_next(int b, bit up, bit dn);
    if (up && dn) return b;
    if (up) return (b + BSTEP > BMAX) ? BMAX : b + BSTEP;
    if (dn) return (b - BSTEP < BMIN) ? BMIN : b - BSTEP;
    return b;
  endfunction

  function automatic int ref_preset(int p);
    return (BMIN + BSTEP * p > BMAX) ? BMAX : BMIN + BSTEP * p;
  endfunction

  function automatic logic [11:0] ref_digits(int b);
    logic [11:0] d;
    d = {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
    return d;
  endfunction

  // ---------------------------------------------------------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    bus.tapup_n     = 1'b1;
    bus.tapdown_n   = 1'b1;
    bus.preset      = 5'd0;
    bus.load_preset = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_bpm = BMIN;
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    if (up) bus.tapup_n = 1'b0;
    if (dn) bus.tapdown_n = 1'b0;
    tick(hold);
    bus.tapup_n   = 1'b1;
    bus.tapdown_n = 1'b1;
    tick(DEB + 8);
  endtask

  task automatic wait_advance(input int limit, output int cycles);
    logic [3:0] s0;
    s0 = bus.step;
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      tick(1);
      if (bus.step !== s0) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic wait_beat(input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      tick(1);
      if (bus.beat === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    int c;
    do_reset();
    vectors++; if (bus.bpm !== 8'(BMIN)) begin miscompares++; $display("FAIL reset_bpm got %0d want %0d", bus.bpm, BMIN); end
    vectors++; if ({bus.hex100, bus.hex10, bus.hex0} !== 12'h060) begin miscompares++; $display("FAIL reset_hex got %h want 060", {bus.hex100, bus.hex10, bus.hex0}); end
    vectors++; if (bus.step !== 4'd0) begin miscompares++; $display("FAIL reset_step got %0d want 0", bus.step); end
    vectors++; if (bus.led !== 8'h01) begin miscompares++; $display("FAIL reset_led got %h want 01", bus.led); end
    vectors++; if (bus.beat !== 1'b0 || bus.speaker !== 1'b0) begin miscompares++; $display("FAIL reset_beat_spk got %b%b want 00", bus.beat, bus.speaker); end
    // Release is synchronised internally, so allow a few cycles beyond THRESH/BPM_MIN.
    wait_advance(200, c);
    vectors++; if (c < THRESH / BMIN || c > THRESH / BMIN + 3) begin miscompares++; $display("FAIL first_advance got %0d want %0d..%0d", c, THRESH / BMIN, THRESH / BMIN + 3); end
    for (int i = 0; i < 3; i++) begin
      wait_advance(200, c);
      vectors++; if (c != THRESH / BMIN) begin miscompares++; $display("FAIL step_interval got %0d want %0d", c, THRESH / BMIN); end
    end
    wait_beat(1500, c);
    vectors++; if (c < 0) begin miscompares++; $display("FAIL beat_timeout got none want pulse"); end
    tick(1);
    vectors++; if (bus.beat !== 1'b0) begin miscompares++; $display("FAIL beat_width got %b want 0", bus.beat); end
    wait_beat(1500, c);
    vectors++; if (c + 1 != STEPS * THRESH / BMIN) begin miscompares++; $display("FAIL beat_period got %0d want %0d", c + 1, STEPS * THRESH / BMIN); end
  endtask

  task automatic test_sweep();
    logic [7:0] order [14];
    logic [3:0] s0;
    int c, hi, want_hi;
    order = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
              8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    wait_beat(1500, c);
    vectors++; if (c < 0) begin miscompares++; $display("FAIL sweep_sync got none want beat"); end
    for (int i = 0; i < 14; i++) begin
      vectors++; if (bus.led !== order[i]) begin miscompares++; $display("FAIL sweep_led[%0d] got %h want %h", i, bus.led, order[i]); end
      hi = 0;
      c = -1;
      s0 = bus.step;
      for (int n = 1; n <= 200; n++) begin
        if (bus.speaker === 1'b1) hi++;
        tick(1);
        if (bus.step !== s0) begin
          c = n;
          break;
        end
      end
      want_hi = (i == 0 || i == 7) ? CLICK : 0;
      vectors++; if (hi != want_hi || c < 0) begin miscompares++; $display("FAIL sweep_speaker[%0d] got %0d high (adv %0d) want %0d", i, hi, c, want_hi); end
    end
    vectors++; if (bus.led !== 8'h01 || bus.beat !== 1'b1 || bus.step !== 4'd0) begin
      miscompares++; $display("FAIL sweep_wrap got led %h beat %b step %0d want 01 1 0", bus.led, bus.beat, bus.step);
    end
  endtask

  task automatic test_debounce();
    logic [7:0]  prev;
    logic [11:0] hex_old, hex_new;
    int changes;
    bit pend;
    bus.tapup_n = 1'b0;
    tick(3);
    bus.tapup_n = 1'b1;
    tick(20);
    vectors++; if (bus.bpm !== 8'(model_bpm)) begin miscompares++; $display("FAIL debounce_glitch got %0d want %0d", bus.bpm, model_bpm); end

    bus.tapup_n = 1'b0;
    prev = bus.bpm;
    changes = 0;
    pend = 1'b0;
    hex_old = 12'hfff;
    hex_new = 12'hfff;
    for (int n = 0; n < 40; n++) begin
      if (n == 20) bus.tapup_n = 1'b1;
      tick(1);
      if (pend) begin
        hex_new = {bus.hex100, bus.hex10, bus.hex0};
        pend = 1'b0;
      end
      if (bus.bpm !== prev) begin
        changes++;
        if (changes == 1) begin
          hex_old = {bus.hex100, bus.hex10, bus.hex0};
          pend = 1'b1;
        end
        prev = bus.bpm;
      end
    end
    model_bpm = ref_next(model_bpm, 1'b1, 1'b0);
    vectors++; if (changes != 1) begin miscompares++; $display("FAIL debounce_once got %0d changes want 1", changes); end
    vectors++; if (bus.bpm !== 8'(model_bpm)) begin miscompares++; $display("FAIL debounce_bpm got %0d want %0d", bus.bpm, model_bpm); end
    vectors++; if (hex_old !== ref_digits(model_bpm - BSTEP) || hex_new !== ref_digits(model_bpm)) begin
      miscompares++; $display("FAIL debounce_hex got %h then %h want %h then %h", hex_old, hex_new, ref_digits(model_bpm - BSTEP), ref_digits(model_bpm));
    end
  endtask

  task automatic test_saturation();
    for (int dir = 0; dir < 2; dir++) begin
      for (int i = 0; i < 20; i++) begin
        press(dir == 0, dir == 1, $urandom_range(8, 14));
        model_bpm = ref_next(model_bpm, dir == 0, dir == 1);
        vectors++; if (bus.bpm !== 8'(model_bpm) || {bus.hex100, bus.hex10, bus.hex0} !== ref_digits(model_bpm)) begin
          miscompares++; $display("FAIL saturate[%0d,%0d] got %0d/%h want %0d/%h", dir, i, bus.bpm, {bus.hex100, bus.hex10, bus.hex0}, model_bpm, ref_digits(model_bpm));
        end
      end
      vectors++; if (bus.bpm !== 8'(dir == 0 ? BMAX : BMIN)) begin miscompares++; $display("FAIL saturate_end[%0d] got %0d want %0d", dir, bus.bpm, dir == 0 ? BMAX : BMIN); end
    end
  endtask

  task automatic test_presets();
    int p;
    bus.preset = 5'd4;
    bus.load_preset = 1'b1;
    tick(3);
    vectors++; if (bus.bpm !== 8'd100 || {bus.hex100, bus.hex10, bus.hex0} !== 12'h100) begin
      miscompares++; $display("FAIL preset4 got %0d/%h want 100/100", bus.bpm, {bus.hex100, bus.hex10, bus.hex0});
    end
    press(1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 10);
    vectors++; if (bus.bpm !== 8'd100) begin miscompares++; $display("FAIL preset_keys_ignored got %0d want 100", bus.bpm); end
    bus.preset = 5'd31;
    tick(3);
    vectors++; if (bus.bpm !== 8'(BMAX) || {bus.hex100, bus.hex10, bus.hex0} !== 12'h230) begin
      miscompares++; $display("FAIL preset31 got %0d/%h want 230/230", bus.bpm, {bus.hex100, bus.hex10, bus.hex0});
    end
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 31);
      bus.preset = 5'(p);
      tick(3);
      model_bpm = ref_preset(p);
      vectors++; if (bus.bpm !== 8'(model_bpm) || {bus.hex100, bus.hex10, bus.hex0} !== ref_digits(model_bpm)) begin
        miscompares++; $display("FAIL preset_rand[%0d] got %0d/%h want %0d/%h", p, bus.bpm, {bus.hex100, bus.hex10, bus.hex0}, model_bpm, ref_digits(model_bpm));
      end
    end
    bus.load_preset = 1'b0;
    tick(5);
    vectors++; if (bus.bpm !== 8'(model_bpm)) begin miscompares++; $display("FAIL preset_hold got %0d want %0d", bus.bpm, model_bpm); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b1, $urandom_range(8, 14));
      vectors++; if (bus.bpm !== 8'(model_bpm)) begin miscompares++; $display("FAIL simultaneous[%0d] got %0d want %0d", i, bus.bpm, model_bpm); end
    end
  endtask

  task automatic test_random();
    int kind, hold;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      if (kind >= 3) hold = $urandom_range(1, DEB - 1);
      else           hold = $urandom_range(8, 14);
      press(kind == 0 || kind == 2 || kind == 3, kind == 1 || kind == 2 || kind == 4, hold);
      if (kind < 3) model_bpm = ref_next(model_bpm, kind != 1, kind != 0);
      vectors++; if (bus.bpm !== 8'(model_bpm) || {bus.hex100, bus.hex10, bus.hex0} !== ref_digits(model_bpm)) begin
        miscompares++; $display("FAIL random[%0d] kind %0d hold %0d got %0d/%h want %0d/%h", i, kind, hold, bus.bpm, {bus.hex100, bus.hex10, bus.hex0}, model_bpm, ref_digits(model_bpm));
      end
    end
  endtask

  task automatic test_drift(input int p);
    int c, total, lo, hi, ilo, ihi;
    bit timeout;
    bus.preset = 5'(p);
    bus.load_preset = 1'b1;
    tick(3);
    bus.load_preset = 1'b0;
    model_bpm = ref_preset(p);
    vectors++; if (bus.bpm !== 8'(model_bpm)) begin miscompares++; $display("FAIL drift_bpm got %0d want %0d", bus.bpm, model_bpm); end
    ilo = THRESH / model_bpm;
    ihi = ilo + ((THRESH % model_bpm) != 0 ? 1 : 0);
    lo  = 150 * THRESH / model_bpm;
    hi  = lo + (((150 * THRESH) % model_bpm) != 0 ? 1 : 0);
    wait_advance(300, c);
    total = 0;
    timeout = (c < 0);
    for (int i = 0; i < 150 && !timeout; i++) begin
      wait_advance(300, c);
      if (c < 0) timeout = 1'b1;
      total += c;
      vectors++; if (c < ilo || c > ihi) begin miscompares++; $display("FAIL drift_interval[%0d] got %0d want %0d..%0d", i, c, ilo, ihi); end
    end
    vectors++; if (timeout || total < lo || total > hi) begin miscompares++; $display("FAIL drift_total bpm %0d got %0d want %0d..%0d", model_bpm, total, lo, hi); end
  endtask

  task automatic test_reset_midsweep();
    int c;
    tick($urandom_range(10, 60));
    reset = 1'b1;
    #1;
    vectors++; if (bus.step !== 4'd0 || bus.led !== 8'h01 || bus.bpm !== 8'(BMIN) || bus.speaker !== 1'b0) begin
      miscompares++; $display("FAIL midsweep_reset got step %0d led %h bpm %0d spk %b want 0 01 %0d 0", bus.step, bus.led, bus.bpm, bus.speaker, BMIN);
    end
    tick(3);
    reset = 1'b0;
    model_bpm = BMIN;
    wait_advance(200, c);
    vectors++; if (c < THRESH / BMIN || c > THRESH / BMIN + 3) begin miscompares++; $display("FAIL midsweep_first_advance got %0d want %0d..%0d", c, THRESH / BMIN, THRESH / BMIN + 3); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_debounce();
    test_saturation();
    test_presets();
    test_simultaneous();
    test_random();
    test_drift(9);   // 150 bpm, exact 40-cycle steps
    test_drift(1);   // 70 bpm, fractional 85.7-cycle steps
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
